bram_scan_ctrl: RTL

Sequencer for the serial scan harness that wraps a RAMB36E1 under test. The harness has a DIN_N-bit input shift register fed from `di`, a `stb` that loads it onto the BRAM pins and captures the BRAM outputs, and a DOUT_N-bit output shift register read from `do`. This block takes parallel stimulus vectors over a valid/ready handshake and serialises each one into the harness. It then strobes the harness, deserialises the captured response, and returns it over a second valid/ready handshake. It sits between the host test logic and the harness `di`/`stb`/`do` pins.

---
 rtl/bram_scan_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bram_scan_ctrl.sv
// bram_scan_ctrl: serialises stimulus into the RAMB36E1 scan harness, strobes it, deserialises the response.
// Rev 1.0
`default_nettype none

module bram_scan_ctrl #(
  parameter int DIN_N  = 8,
  parameter int DOUT_N = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DIN_N-1:0]  vec_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DOUT_N-1:0] res_data,
  output logic              scan_di,
  output logic              scan_stb,
  input  logic              scan_do,
  output logic              busy,
  output logic [CNT_W-1:0]  scan_cnt
);

  localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int BIT_W = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIN_N-1:0]  sbuf_q, sbuf_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DOUT_N-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic              vec_ready_q, vec_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              scan_di_q, scan_di_d;
  logic              scan_stb_q, scan_stb_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sbuf_q      <= '0;
      bit_cnt_q   <= '0;
      res_data_q  <= '0;
      scan_cnt_q  <= '0;
      vec_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      scan_di_q   <= 1'b0;
      scan_stb_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sbuf_q      <= sbuf_d;
      bit_cnt_q   <= bit_cnt_d;
      res_data_q  <= res_data_d;
      scan_cnt_q  <= scan_cnt_d;
      vec_ready_q <= vec_ready_d;
      res_valid_q <= res_valid_d;
      scan_di_q   <= scan_di_d;
      scan_stb_q  <= scan_stb_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sbuf_d      = sbuf_q;
    bit_cnt_d   = bit_cnt_q;
    res_data_d  = res_data_q;
    scan_cnt_d  = scan_cnt_q;
    scan_di_d   = 1'b0;
    scan_stb_d  = 1'b0;
    res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // The MSB goes out in the very first SHIFT cycle, so the buffer keeps only the rest.
        if (vec_valid && vec_ready_q) begin
          scan_di_d = vec_data[DIN_N-1];
          sbuf_d    = vec_data << 1;
          bit_cnt_d = BIT_W'(DIN_N - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          scan_di_d = sbuf_q[DIN_N-1];
          sbuf_d    = sbuf_q << 1;
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end else begin
          scan_stb_d = 1'b1;
          state_d    = STROBE;
        end
      end
      STROBE: begin
        bit_cnt_d = BIT_W'(DOUT_N - 1);
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        res_data_d = (res_data_q << 1) | DOUT_N'(scan_do);
        if (bit_cnt_q == '0) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          scan_cnt_d = scan_cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vec_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign vec_ready = vec_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign scan_di   = scan_di_q;
  assign scan_stb  = scan_stb_q;
  assign busy      = busy_q;
  assign scan_cnt  = scan_cnt_q;

endmodule

`default_nettype wire
